// File: rtl/spike_pkg.sv
`default_nettype none
// ============================================================================
// Module   : spike_pkg
// Brief    : Shared types and constants for the spike ISI encoder.
// Revision : 1.0
// ============================================================================
package spike_pkg;

    localparam int ISI_W_DEFAULT = 8;
    localparam logic [ISI_W_DEFAULT-1:0] ISI_MAX = '1;

    // One FIFO entry: saturation flag above the interval value.
    typedef struct packed {
        logic                     sat;
        logic [ISI_W_DEFAULT-1:0] isi;
    } isi_word_t;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        ARMED = 1'b1
    } isi_state_e;

endpackage
`default_nettype wire

// File: rtl/spike_fifo.sv
`default_nettype none
// ============================================================================
// Module   : spike_fifo
// Brief    : First-word fall-through FIFO; push while full succeeds only
//            when a pop happens in the same cycle.
// Revision : 1.0
// ============================================================================
module spike_fifo #(
    parameter int WIDTH = 9,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         data_i,
    input  logic                     pop_i,
    output logic [WIDTH-1:0]         data_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int c_AW = $clog2(DEPTH);

    logic [c_AW:0]      wr_ptr_q;
    logic [c_AW:0]      rd_ptr_q;
    logic [WIDTH-1:0]   mem_q [DEPTH];
    logic               w_wr_en;
    logic               w_rd_en;

    // Extra pointer bit distinguishes full from empty when the indices match.
    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign full_o  = (wr_ptr_q[c_AW] != rd_ptr_q[c_AW]) &&
                     (wr_ptr_q[c_AW-1:0] == rd_ptr_q[c_AW-1:0]);
    assign count_o = wr_ptr_q - rd_ptr_q;

    assign w_rd_en = pop_i & ~empty_o;
    assign w_wr_en = push_i & (~full_o | w_rd_en);

    assign data_o = empty_o ? '0 : mem_q[rd_ptr_q[c_AW-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (w_wr_en) wr_ptr_q <= wr_ptr_q + (c_AW+1)'(1);
            if (w_rd_en) rd_ptr_q <= rd_ptr_q + (c_AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (w_wr_en) mem_q[wr_ptr_q[c_AW-1:0]] <= data_i;
    end

endmodule
`default_nettype wire

// File: rtl/spike_isi_encoder.sv
`default_nettype none
// ============================================================================
// Module   : spike_isi_encoder
// Brief    : Measures inter-spike intervals and streams them out of a FIFO.
//            Define SPIKE_RATE_WINDOW_EN to add the windowed spike-rate counter.
// Revision : 1.0
// ============================================================================
module spike_isi_encoder
    import spike_pkg::*;
#(
    parameter int ISI_W  = ISI_W_DEFAULT,
    parameter int DEPTH  = 4,
    parameter int WINDOW = 256
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      ena,
    input  logic                      spike_in,
    input  logic                      clr_drop,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [ISI_W-1:0]          out_isi,
    output logic                      out_sat,
    output logic [$clog2(DEPTH):0]    fifo_count,
    output logic                      dropped,
    output logic [ISI_W-1:0]          rate_count,
    output logic                      rate_strobe
);

    localparam logic [ISI_W-1:0] c_MAX = '1;

    isi_state_e        state_q, state_d;
    logic [ISI_W-1:0]  cnt_q, cnt_d;
    logic              spike_q;
    logic              dropped_q, dropped_d;
    logic              w_edge;
    logic              w_push;
    logic              w_pop;
    logic              w_full;
    logic              w_empty;
    logic              w_drop;
    logic [ISI_W:0]    w_push_word;
    logic [ISI_W:0]    w_head_word;

    // Marker blocks appear only for unusable parameter values.
    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_depth_invalid
    end
    if (WINDOW < 2) begin : g_window_invalid
    end

    assign w_edge = spike_in & ~spike_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            spike_q   <= 1'b0;
            state_q   <= IDLE;
            cnt_q     <= '0;
            dropped_q <= 1'b0;
        end else begin
            spike_q   <= spike_in;
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            dropped_q <= dropped_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        w_push  = 1'b0;
        if (ena) begin
            case (state_q)
                IDLE: begin
                    if (w_edge) begin
                        state_d = ARMED;
                        cnt_d   = ISI_W'(1);
                    end
                end
                ARMED: begin
                    if (w_edge) begin
                        w_push = 1'b1;
                        cnt_d  = ISI_W'(1);
                    end else if (cnt_q != c_MAX) begin
                        cnt_d = cnt_q + ISI_W'(1);
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // A counter pinned at max means the true interval reached or exceeded it.
    assign w_push_word = {(cnt_q == c_MAX), cnt_q};
    assign w_pop       = ~w_empty & out_ready;
    assign w_drop      = w_push & w_full & ~w_pop;

    always_comb begin
        dropped_d = dropped_q;
        if (w_drop)        dropped_d = 1'b1;
        else if (clr_drop) dropped_d = 1'b0;
    end

    spike_fifo #(
        .WIDTH (ISI_W + 1),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (w_push),
        .data_i  (w_push_word),
        .pop_i   (w_pop),
        .data_o  (w_head_word),
        .full_o  (w_full),
        .empty_o (w_empty),
        .count_o (fifo_count)
    );

    assign out_valid = ~w_empty;
    assign out_sat   = w_head_word[ISI_W];
    assign out_isi   = w_head_word[ISI_W-1:0];
    assign dropped   = dropped_q;

`ifdef SPIKE_RATE_WINDOW_EN
    localparam int                 c_WIN_W    = (WINDOW > 1) ? $clog2(WINDOW) : 1;
    localparam logic [c_WIN_W-1:0] c_WIN_LAST = c_WIN_W'(WINDOW - 1);

    logic [c_WIN_W-1:0] win_q;
    logic [ISI_W-1:0]   acc_q;
    logic [ISI_W-1:0]   rate_q;
    logic               strobe_q;
    logic [ISI_W-1:0]   w_acc_inc;

    // Edge in the final window cycle still lands in that window's total.
    assign w_acc_inc = (w_edge && acc_q != c_MAX) ? acc_q + ISI_W'(1) : acc_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            win_q    <= '0;
            acc_q    <= '0;
            rate_q   <= '0;
            strobe_q <= 1'b0;
        end else begin
            strobe_q <= 1'b0;
            if (ena) begin
                if (win_q == c_WIN_LAST) begin
                    rate_q   <= w_acc_inc;
                    strobe_q <= 1'b1;
                    acc_q    <= '0;
                    win_q    <= '0;
                end else begin
                    acc_q <= w_acc_inc;
                    win_q <= win_q + c_WIN_W'(1);
                end
            end
        end
    end

    assign rate_count  = rate_q;
    assign rate_strobe = strobe_q;
`else
    assign rate_count  = '0;
    assign rate_strobe = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_spike_isi_encoder.sv
`default_nettype none
// ============================================================================
// Module   : tb_spike_isi_encoder
// Brief    : Directed bench for spike_isi_encoder with a timestamp-based model.
// Revision : 1.0
// ============================================================================
module tb_spike_isi_encoder;
    import spike_pkg::*;

    localparam int ISI_W  = 8;
    localparam int DEPTH  = 4;
    localparam int WINDOW = 16;
    localparam int CW     = $clog2(DEPTH) + 1;
    localparam int MAXV   = (1 << ISI_W) - 1;
`ifdef SPIKE_RATE_WINDOW_EN
    localparam bit RATE_ON = 1'b1;
`else
    localparam bit RATE_ON = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst_n, ena, spike_in, clr_drop, out_ready;
    logic             out_valid, out_sat, dropped, rate_strobe;
    logic [ISI_W-1:0] out_isi, rate_count;
    logic [CW-1:0]    fifo_count;

    always #5 clk = ~clk;

    spike_isi_encoder #(
        .ISI_W  (ISI_W),
        .DEPTH  (DEPTH),
        .WINDOW (WINDOW)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .ena         (ena),
        .spike_in    (spike_in),
        .clr_drop    (clr_drop),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_isi     (out_isi),
        .out_sat     (out_sat),
        .fifo_count  (fifo_count),
        .dropped     (dropped),
        .rate_count  (rate_count),
        .rate_strobe (rate_strobe)
    );

    int n_chk = 0;
    int n_pass = 0;
    int n_strobe = 0;
    int s0;

    // Model: edges are timestamped by the count of enabled cycles since reset.
    isi_word_t q[$];
    int        act_idx, m_last, win_edges, m_rate, m_last_push, m_isi;
    bit        m_armed, m_prev, m_dropped, m_strobe, m_drop, m_strobe_n;
    isi_word_t m_w;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: actual %0d required %0d (t=%0t)", nm, act, exp, $time);
    endtask

    task automatic model_reset();
        q.delete();
        act_idx = 0; m_last = 0; win_edges = 0; m_rate = 0; m_last_push = 0;
        m_armed = 0; m_prev = 0; m_dropped = 0; m_strobe = 0;
    endtask

    // Applies one clock edge worth of inputs to the model.
    task automatic model_step();
        m_strobe_n = 0;
        m_drop     = 0;
        if (q.size() > 0 && out_ready) q.delete(0);
        if (ena) begin
            if (spike_in && !m_prev) begin
                if (m_armed) begin
                    m_isi       = act_idx - m_last;
                    m_w.sat     = (m_isi >= MAXV);
                    m_w.isi     = m_w.sat ? ISI_MAX : ISI_W'(m_isi);
                    m_last_push = m_isi;
                    if (q.size() < DEPTH) q.push_back(m_w);
                    else m_drop = 1;
                end
                m_armed = 1;
                m_last  = act_idx;
                win_edges++;
            end
            if (act_idx % WINDOW == WINDOW - 1) begin
                m_rate     = (win_edges > MAXV) ? MAXV : win_edges;
                win_edges  = 0;
                m_strobe_n = 1;
            end
            act_idx++;
        end
        m_prev = spike_in;
        if (m_drop) m_dropped = 1;
        else if (clr_drop) m_dropped = 0;
        m_strobe = m_strobe_n;
    endtask

    task automatic compare();
        isi_word_t h;
        chk("valid", out_valid, q.size() > 0);
        if (q.size() > 0) begin
            h = q[0];
            chk("isi", out_isi, h.isi);
            chk("sat", out_sat, h.sat);
        end else begin
            chk("isi_empty", out_isi, 0);
            chk("sat_empty", out_sat, 0);
        end
        chk("count", fifo_count, q.size());
        chk("dropped", dropped, m_dropped);
        chk("rate_count", rate_count, RATE_ON ? m_rate : 0);
        chk("rate_strobe", rate_strobe, RATE_ON ? m_strobe : 0);
        if (rate_strobe) n_strobe++;
    endtask

    task automatic cyc(input bit sp, input bit en, input bit rd, input bit cl);
        @(negedge clk);
        compare();
        #1;
        spike_in = sp; ena = en; out_ready = rd; clr_drop = cl;
        model_step();
    endtask

    task automatic gap(input int n, input bit en, input bit rd);
        for (int i = 0; i < n; i++) cyc(1'b0, en, rd, 1'b0);
    endtask

    task automatic settle();
        @(posedge clk);
        #2;
    endtask

    initial begin
        rst_n = 1'b0; ena = 1'b0; spike_in = 1'b0; clr_drop = 1'b0; out_ready = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        chk("rst_valid", out_valid, 0);
        chk("rst_count", fifo_count, 0);
        chk("rst_dropped", dropped, 0);
        chk("rst_isi", out_isi, 0);
        chk("rst_rate", rate_count, 0);
        #1 rst_n = 1'b1;

        // First edge only arms the measurement.
        cyc(1, 1, 1, 0);
        settle();
        chk("t1_no_push_valid", out_valid, 0);
        chk("t1_no_push_count", fifo_count, 0);

        // Edges 5 apart, then with one low cycle between.
        gap(4, 1, 1);
        cyc(1, 1, 1, 0);
        settle();
        chk("t2_valid", out_valid, 1);
        chk("t2_isi5", out_isi, 5);
        chk("t2_sat0", out_sat, 0);
        chk("t2_model5", m_last_push, 5);
        cyc(0, 1, 1, 0);
        cyc(1, 1, 1, 0);
        settle();
        chk("t2_isi2", out_isi, 2);

        // Saturation boundary: 254 is exact, 255 and beyond saturate.
        gap(253, 1, 1);
        cyc(1, 1, 1, 0);
        settle();
        chk("t3_isi254", out_isi, 254);
        chk("t3_sat254", out_sat, 0);
        gap(254, 1, 1);
        cyc(1, 1, 1, 0);
        settle();
        chk("t3_isi255", out_isi, 255);
        chk("t3_sat255", out_sat, 1);
        gap(299, 1, 1);
        cyc(1, 1, 1, 0);
        settle();
        chk("t3_isi300", out_isi, 255);
        chk("t3_sat300", out_sat, 1);
        chk("t3_model300", m_last_push, 300);

        // Overflow with the consumer stalled.
        cyc(0, 1, 1, 0);
        for (int i = 0; i < 6; i++) begin
            cyc(1, 1, 0, 0);
            cyc(0, 1, 0, 0);
            cyc(0, 1, 0, 0);
        end
        settle();
        chk("t4_full_count", fifo_count, 4);
        chk("t4_dropped", dropped, 1);
        cyc(0, 1, 0, 1);
        settle();
        chk("t4_clr", dropped, 0);
        cyc(1, 1, 1, 0);
        settle();
        chk("t4_pushpop_count", fifo_count, 4);
        chk("t4_pushpop_nodrop", dropped, 0);
        cyc(0, 1, 0, 0);
        cyc(1, 1, 0, 1);
        settle();
        chk("t4_set_wins", dropped, 1);
        chk("t4_still_full", fifo_count, 4);
        cyc(0, 1, 0, 1);
        settle();
        chk("t4_clr2", dropped, 0);

        // Enable gating: disabled cycles neither count nor detect edges.
        gap(6, 1, 1);
        cyc(1, 1, 1, 0);
        gap(3, 1, 1);
        for (int i = 0; i < 20; i++) cyc(i % 2 == 0, 0, 1, 0);
        settle();
        chk("t5_no_push", out_valid, 0);
        chk("t5_no_push_count", fifo_count, 0);
        cyc(0, 1, 1, 0);
        cyc(0, 1, 1, 0);
        cyc(1, 1, 1, 0);
        settle();
        chk("t5_isi6", out_isi, 6);
        chk("t5_model6", m_last_push, 6);

        // Fresh reset, then one window with three edges.
        @(negedge clk);
        #1 rst_n = 1'b0; ena = 1'b0; spike_in = 1'b0; clr_drop = 1'b0; out_ready = 1'b0;
        model_reset();
        @(negedge clk);
        #1 rst_n = 1'b1;
        s0 = n_strobe;
        for (int i = 0; i < 20; i++) cyc(i == 2 || i == 5 || i == 8, 1, 0, 0);
        settle();
        chk("t6_rate3", rate_count, RATE_ON ? 3 : 0);
        chk("t6_one_strobe", n_strobe - s0, RATE_ON ? 1 : 0);
        chk("t6_count2", fifo_count, 2);
        chk("t6_head3", out_isi, 3);

        // Asynchronous reset mid-window clears outputs without a clock.
        cyc(1, 1, 0, 0);
        @(negedge clk);
        #3 rst_n = 1'b0;
        #1;
        chk("t6_rst_valid", out_valid, 0);
        chk("t6_rst_count", fifo_count, 0);
        chk("t6_rst_isi", out_isi, 0);
        chk("t6_rst_sat", out_sat, 0);
        chk("t6_rst_dropped", dropped, 0);
        chk("t6_rst_rate", rate_count, 0);
        chk("t6_rst_strobe", rate_strobe, 0);
        ena = 1'b0; spike_in = 1'b0; out_ready = 1'b0; clr_drop = 1'b0;
        model_reset();
        @(negedge clk);
        #1 rst_n = 1'b1;
        gap(4, 1, 1);
        @(negedge clk);
        compare();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
